// File: rtl/dmem_responder.sv
// Data-memory responder: target side of the core's load/store request interface.
// One request at a time, WAIT programmable wait states, little-endian byte/half/word access.
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int WAIT_LOAD = (WAIT > 0) ? WAIT - 1 : 0;

  state_t              state, next_state;
  logic [2:0]          cnt;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic                ready_q, err_q;
  logic [31:0]         rdata_q;

  logic [31:0]         mem [2**ADDR_W];
  logic [ADDR_W-1:0]   idx;

  logic                fault;
  logic [31:0]         load_val;
  logic [3:0]          be;
  logic [31:0]         wval;

  assign idx = addr_q[ADDR_W+1:2];

  // State register and wait counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && req)
        cnt <= 3'(WAIT_LOAD);
      else if (state == S_WAIT && cnt != 3'd0)
        cnt <= cnt - 3'd1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (req) next_state = (WAIT > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt == 3'd0) next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    ready = ready_q;
    err   = err_q;
    rdata = rdata_q;
  end

  // Request fields are captured only in IDLE; later input activity is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (state == S_IDLE && req) begin
      we_q    <= we;
      f3_q    <= funct3;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  always_comb begin
    logic bad_f3, misalign, out_of_range;
    bad_f3 = we_q ? (f3_q[2] || f3_q[1:0] == 2'b11)
                  : (f3_q == 3'b011 || f3_q == 3'b110 || f3_q == 3'b111);
    misalign = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
               (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    out_of_range = (addr_q >> (ADDR_W + 2)) != 32'd0;
    fault = bad_f3 || misalign || out_of_range;
  end

  // Load extraction: select the lane, then sign- or zero-extend.
  always_comb begin
    logic [31:0] word_rd;
    logic [7:0]  byte_rd;
    logic [15:0] half_rd;
    word_rd = mem[idx];
    byte_rd = word_rd[{addr_q[1:0], 3'b000} +: 8];
    half_rd = word_rd[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_val = {{24{byte_rd[7]}}, byte_rd};
      3'b001:  load_val = {{16{half_rd[15]}}, half_rd};
      3'b100:  load_val = {24'd0, byte_rd};
      3'b101:  load_val = {16'd0, half_rd};
      default: load_val = word_rd;
    endcase
  end

  // Store lanes: replicate the narrow data across the word and enable only the addressed bytes.
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be   = 4'b0001 << addr_q[1:0];
        wval = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wval = {2{wdata_q[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wval = wdata_q;
      end
    endcase
  end

  // Response registers load on the edge leaving RESP, so they are valid at E0+WAIT+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= (state == S_RESP);
      err_q   <= (state == S_RESP) && fault;
      if (state == S_RESP)
        rdata_q <= (fault || we_q) ? 32'd0 : load_val;
    end
  end

  // NOTE: the array has no reset; an aborted store never reaches RESP, so it is never written.
  always_ff @(posedge clk) begin
    if (state == S_RESP && we_q && !fault) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wval[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with WAIT=1, ADDR_W=8.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  dmem_responder #(.ADDR_W(8), .WAIT(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .rdata  (rdata),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One complete request; lat counts edges after the capture edge until ready (-1 on timeout).
  task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic e,
                        output int lat);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = -1; rd = 32'd0; e = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = c; rd = rdata; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({ready, err, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: ready/err/busy=%b expected 000", {ready, err, busy});
    end
    tests_run++;
    if (rdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h expected 00000000", rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e, lat);
    tests_run++;
    if (lat !== 2 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL sw_latency: lat=%0d err=%b expected lat=2 err=0", lat, e);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    tests_run++;
    if (lat !== 2 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL lw_after_sw: lat=%0d err=%b rdata=%h expected 2 0 deadbeef", lat, e, rd);
    end
  endtask

  task automatic test_sb_loads();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 3'b010, 32'h10, 32'h11223344, rd, e, lat);
    do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, rd, e, lat);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    tests_run++;
    if (rd !== 32'hA5223344 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_lw: got %h err=%b expected a5223344 err=0", rd, e);
    end
    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, e, lat);
    tests_run++;
    if (rd !== 32'hFFFFFFA5) begin
      tests_failed++;
      $display("FAIL sb_lb: got %h expected ffffffa5", rd);
    end
    do_req(1'b0, 3'b100, 32'h13, 32'h0, rd, e, lat);
    tests_run++;
    if (rd !== 32'h000000A5) begin
      tests_failed++;
      $display("FAIL sb_lbu: got %h expected 000000a5", rd);
    end
  endtask

  task automatic test_sh_loads();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 3'b010, 32'h20, 32'h12345678, rd, e, lat);
    do_req(1'b1, 3'b001, 32'h22, 32'h00008001, rd, e, lat);
    do_req(1'b0, 3'b001, 32'h22, 32'h0, rd, e, lat);
    tests_run++;
    if (rd !== 32'hFFFF8001) begin
      tests_failed++;
      $display("FAIL sh_lh: got %h expected ffff8001", rd);
    end
    do_req(1'b0, 3'b101, 32'h22, 32'h0, rd, e, lat);
    tests_run++;
    if (rd !== 32'h00008001) begin
      tests_failed++;
      $display("FAIL sh_lhu: got %h expected 00008001", rd);
    end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
    tests_run++;
    if (rd !== 32'h80015678) begin
      tests_failed++;
      $display("FAIL sh_low_half: got %h expected 80015678", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b0, 3'b010, 32'h11, 32'h0, rd, e, lat);
    tests_run++;
    if (e !== 1'b1 || rd !== 32'd0 || lat !== 2) begin
      tests_failed++;
      $display("FAIL err_lw_misalign: err=%b rdata=%h lat=%0d expected 1 00000000 2", e, rd, lat);
    end
    do_req(1'b1, 3'b001, 32'h23, 32'h0000FFFF, rd, e, lat);
    tests_run++;
    if (e !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sh_misalign: err=%b expected 1", e);
    end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
    tests_run++;
    if (rd !== 32'h80015678 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_sh_no_write: got %h err=%b expected 80015678 err=0", rd, e);
    end
    do_req(1'b0, 3'b010, 32'h400, 32'h0, rd, e, lat);
    tests_run++;
    if (e !== 1'b1 || rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL err_out_of_range: err=%b rdata=%h expected 1 00000000", e, rd);
    end
    do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, e, lat);
    tests_run++;
    if (e !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_bad_funct3: err=%b expected 1", e);
    end
    do_req(1'b1, 3'b100, 32'h10, 32'h0, rd, e, lat);
    tests_run++;
    if (e !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_store_funct3: err=%b expected 1", e);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_pulse_width: ready=%b err=%b expected 0 0", ready, err);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] rd; logic e; int lat; logic saw_ready;
    do_req(1'b1, 3'b010, 32'h30, 32'h11111111, rd, e, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h30; wdata = 32'h99999999;
    @(posedge clk);
    #1 req = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_store_busy: busy=%b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_store_busy_drop: busy=%b expected 0", busy);
    end
    saw_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (ready) saw_ready = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      if (ready) saw_ready = 1'b1;
    end
    tests_run++;
    if (saw_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_store_no_ready: saw ready=%b expected 0", saw_ready);
    end
    do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, e, lat);
    tests_run++;
    if (rd !== 32'h11111111) begin
      tests_failed++;
      $display("FAIL mid_store_old_value: got %h expected 11111111", rd);
    end
  endtask

  task automatic test_held_req();
    int          pulse_cyc[4];
    logic [31:0] pulse_data[4];
    int          n = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (ready && n < 4) begin
        pulse_cyc[n]  = c;
        pulse_data[n] = rdata;
        n++;
      end
    end
    @(negedge clk);
    req = 1'b0;
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("FAIL held_pulse_count: got %0d pulses expected 4", n);
    end else begin
      tests_run++;
      if (pulse_cyc[0] !== 3 || pulse_cyc[1] !== 6 || pulse_cyc[2] !== 9 || pulse_cyc[3] !== 12) begin
        tests_failed++;
        $display("FAIL held_spacing: pulses at %0d %0d %0d %0d expected 3 6 9 12",
                 pulse_cyc[0], pulse_cyc[1], pulse_cyc[2], pulse_cyc[3]);
      end
      tests_run++;
      if (pulse_data[0] !== 32'hA5223344 || pulse_data[1] !== 32'hA5223344) begin
        tests_failed++;
        $display("FAIL held_data: got %h %h expected a5223344 a5223344",
                 pulse_data[0], pulse_data[1]);
      end
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    test_reset();
    test_sw_lw();
    test_sb_loads();
    test_sh_loads();
    test_errors();
    test_reset_mid_store();
    test_held_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
